// File: rtl/fetch_stage_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage.
// Holds the bubble encoding, the opcodes used by neighbouring stages, the
// instruction word size and a word-alignment helper for redirect targets.
package fetch_stage_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

    localparam logic [5:0]  OP_J       = 6'b000010;
    localparam logic [5:0]  OP_JAL     = 6'b000011;
    localparam logic [5:0]  OP_SW      = 6'b101011;
    localparam logic [5:0]  OP_LW      = 6'b100011;

    localparam logic [31:0] WORD_BYTES = 32'd4;

    // Redirect targets are always forced onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register with flush priority, write enable and valid bit.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   flush               - load a bubble (wins over write)
//   write               - load the fetched instruction
//   load_nop            - write a bubble instead of the fetched word (wrong-path fetch)
//   fetch_instr         - instruction word from memory
//   fetch_pc_plus4      - PC+4 of the fetched word
//   instr, pc_plus4, valid - registered outputs toward decode
module fetch_stage_if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        write,
    input  logic        load_nop,
    input  logic [31:0] fetch_instr,
    input  logic [31:0] fetch_pc_plus4,
    output logic [31:0] instr,
    output logic [31:0] pc_plus4,
    output logic        valid
);

    always_ff @(posedge clk) begin
        if (rst || flush || (write && load_nop)) begin
            instr    <= NOP_INSTR;
            pc_plus4 <= 32'd0;
            valid    <= 1'b0;
        end else if (write) begin
            instr    <= fetch_instr;
            pc_plus4 <= fetch_pc_plus4;
            valid    <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC select, pending-redirect
// capture across stalls, IF/ID register and saturating stall/flush counters.
// Ports:
//   Clk, Rst                         - clock, synchronous active-high reset
//   PCWrite, IF_ID_Write, IF_ID_Flush - hazard unit controls
//   BranchTaken/BranchTarget, JumpTaken/JumpTarget - redirect requests
//   IMemAddr / IMemData              - combinational instruction memory port
//   PC                               - current PC
//   IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_Valid - IF/ID register contents
//   StallCount, FlushCount           - saturating performance counters
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             PCWrite,
    input  logic             IF_ID_Write,
    input  logic             IF_ID_Flush,
    input  logic             BranchTaken,
    input  logic [31:0]      BranchTarget,
    input  logic             JumpTaken,
    input  logic [31:0]      JumpTarget,
    output logic [31:0]      IMemAddr,
    input  logic [31:0]      IMemData,
    output logic [31:0]      PC,
    output logic [31:0]      IF_ID_Instruction,
    output logic [31:0]      IF_ID_PCPlus4,
    output logic             IF_ID_Valid,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] pc_plus4;
    logic [31:0] pc_next;
    logic        pend_valid;
    logic [31:0] pend_target;
    logic        consume_pend;

    assign IMemAddr        = PC;
    assign pc_plus4        = PC + WORD_BYTES;
    assign redirect        = JumpTaken | BranchTaken;
    assign redirect_target = word_align(JumpTaken ? JumpTarget : BranchTarget);

    // A held redirect is applied in place of sequential fetch; the word at
    // the current PC was fetched down the wrong path and must not reach decode.
    assign consume_pend    = PCWrite & pend_valid & ~redirect;

    always_comb begin
        pc_next = pc_plus4;
        if (redirect) begin
            pc_next = redirect_target;
        end else if (pend_valid) begin
            pc_next = pend_target;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            PC          <= RESET_PC;
            pend_valid  <= 1'b0;
            pend_target <= 32'd0;
        end else if (PCWrite) begin
            PC          <= pc_next;
            pend_valid  <= 1'b0;
        end else if (redirect) begin
            // Latest redirect during a stall wins.
            pend_valid  <= 1'b1;
            pend_target <= redirect_target;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (!PCWrite && (StallCount != '1)) begin
                StallCount <= StallCount + CNT_W'(1);
            end
            if (IF_ID_Flush && (FlushCount != '1)) begin
                FlushCount <= FlushCount + CNT_W'(1);
            end
        end
    end

    fetch_stage_if_id_reg u_if_id (
        .clk           (Clk),
        .rst           (Rst),
        .flush         (IF_ID_Flush),
        .write         (IF_ID_Write),
        .load_nop      (consume_pend),
        .fetch_instr   (IMemData),
        .fetch_pc_plus4(pc_plus4),
        .instr         (IF_ID_Instruction),
        .pc_plus4      (IF_ID_PCPlus4),
        .valid         (IF_ID_Valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized
// run against a cycle-level reference model of the fetch rules.
module tb_fetch_stage;

    localparam int          CNT_W  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             Clk = 1'b0;
    logic             Rst, PCWrite, IF_ID_Write, IF_ID_Flush;
    logic             BranchTaken, JumpTaken;
    logic [31:0]      BranchTarget, JumpTarget;
    logic [31:0]      IMemAddr, IMemData, PC;
    logic [31:0]      IF_ID_Instruction, IF_ID_PCPlus4;
    logic             IF_ID_Valid;
    logic [CNT_W-1:0] StallCount, FlushCount;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0]      m_pc, m_pt, m_instr, m_pc4;
    logic             m_pv, m_valid;
    logic [CNT_W-1:0] m_sc, m_fc;

    always #5 Clk = ~Clk;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign IMemData = imem_word(IMemAddr);

    fetch_stage #(.RESET_PC(RST_PC), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Rst(Rst), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write),
        .IF_ID_Flush(IF_ID_Flush), .BranchTaken(BranchTaken),
        .BranchTarget(BranchTarget), .JumpTaken(JumpTaken),
        .JumpTarget(JumpTarget), .IMemAddr(IMemAddr), .IMemData(IMemData),
        .PC(PC), .IF_ID_Instruction(IF_ID_Instruction),
        .IF_ID_PCPlus4(IF_ID_PCPlus4), .IF_ID_Valid(IF_ID_Valid),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    // Apply one cycle of inputs, advance the model, clock the DUT, settle.
    task automatic tick(input logic rst, input logic pcw, input logic ifw,
                        input logic fl, input logic br, input logic [31:0] bt,
                        input logic jp, input logic [31:0] jt);
        logic [31:0] tgt, n_pc, n_pt, n_instr, n_pc4;
        logic        redir, n_pv, n_valid, wrong_path;
        logic [CNT_W-1:0] n_sc, n_fc;
        Rst = rst; PCWrite = pcw; IF_ID_Write = ifw; IF_ID_Flush = fl;
        BranchTaken = br; BranchTarget = bt; JumpTaken = jp; JumpTarget = jt;
        redir = jp | br;
        tgt   = jp ? {jt[31:2], 2'b00} : {bt[31:2], 2'b00};
        n_pc = m_pc; n_pv = m_pv; n_pt = m_pt;
        n_instr = m_instr; n_pc4 = m_pc4; n_valid = m_valid;
        n_sc = m_sc; n_fc = m_fc;
        if (rst) begin
            n_pc = RST_PC; n_pv = 0; n_pt = 0;
            n_instr = 0; n_pc4 = 0; n_valid = 0; n_sc = 0; n_fc = 0;
        end else begin
            wrong_path = pcw && m_pv && !redir;
            if (fl || (ifw && wrong_path)) begin
                n_instr = 0; n_pc4 = 0; n_valid = 0;
            end else if (ifw) begin
                n_instr = imem_word(m_pc); n_pc4 = m_pc + 4; n_valid = 1;
            end
            if (pcw) begin
                n_pc = redir ? tgt : (m_pv ? m_pt : m_pc + 4);
                n_pv = 0;
            end else if (redir) begin
                n_pv = 1; n_pt = tgt;
            end
            if (!pcw && m_sc != CNT_MAX) n_sc = m_sc + 1'b1;
            if (fl && m_fc != CNT_MAX)   n_fc = m_fc + 1'b1;
        end
        @(posedge Clk);
        m_pc = n_pc; m_pv = n_pv; m_pt = n_pt; m_instr = n_instr;
        m_pc4 = n_pc4; m_valid = n_valid; m_sc = n_sc; m_fc = n_fc;
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(0, 1, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset;
        tick(1, 1, 1, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 1, 1, 32'h44, 1, 32'h88);
        checks++;
        if ({PC, IMemAddr, IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_Valid, StallCount, FlushCount}
            !== {RST_PC, RST_PC, 32'd0, 32'd0, 1'b0, {CNT_W{1'b0}}, {CNT_W{1'b0}}}) begin
            errors++;
            $display("FAIL reset: pc=%h addr=%h ins=%h pc4=%h v=%b sc=%0d fc=%0d, required pc=%h others 0",
                     PC, IMemAddr, IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_Valid, StallCount, FlushCount, RST_PC);
        end
    endtask

    task automatic test_free_run;
        tick(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            tick(0, 1, 1, 0, 0, 0, 0, 0);
            checks++;
            if ({PC, IF_ID_PCPlus4, IF_ID_Valid, IF_ID_Instruction}
                !== {32'(4 * i), 32'(4 * i), 1'b1, imem_word(32'(4 * (i - 1)))}) begin
                errors++;
                $display("FAIL free_run[%0d]: pc=%h pc4=%h v=%b ins=%h, required pc=%h pc4=%h v=1 ins=%h",
                         i, PC, IF_ID_PCPlus4, IF_ID_Valid, IF_ID_Instruction,
                         32'(4 * i), 32'(4 * i), imem_word(32'(4 * (i - 1))));
            end
        end
    endtask

    task automatic test_stall;
        logic [31:0] held_ins;
        tick(1, 0, 0, 0, 0, 0, 0, 0);
        run(2);
        held_ins = imem_word(32'h4);
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({PC, IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_Valid, StallCount}
            !== {32'h8, held_ins, 32'h8, 1'b1, CNT_W'(3)}) begin
            errors++;
            $display("FAIL stall_hold: pc=%h ins=%h pc4=%h v=%b sc=%0d, required pc=8 ins=%h pc4=8 v=1 sc=3",
                     PC, IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_Valid, StallCount, held_ins);
        end
        run(1);
        checks++;
        if ({PC, IF_ID_PCPlus4} !== {32'hC, 32'hC}) begin
            errors++;
            $display("FAIL stall_release: pc=%h pc4=%h, required pc=c pc4=c", PC, IF_ID_PCPlus4);
        end
    endtask

    task automatic test_branch_flush;
        tick(0, 1, 1, 1, 1, 32'h40, 0, 0);
        checks++;
        if ({PC, IF_ID_Instruction, IF_ID_Valid, FlushCount}
            !== {32'h40, 32'd0, 1'b0, CNT_W'(1)}) begin
            errors++;
            $display("FAIL branch_flush: pc=%h ins=%h v=%b fc=%0d, required pc=40 ins=0 v=0 fc=1",
                     PC, IF_ID_Instruction, IF_ID_Valid, FlushCount);
        end
    endtask

    task automatic test_jump_priority;
        tick(0, 1, 1, 0, 1, 32'h80, 1, 32'h100);
        checks++;
        if (PC !== 32'h100) begin
            errors++;
            $display("FAIL jump_priority: pc=%h, required 100", PC);
        end
    endtask

    task automatic test_pending;
        tick(0, 0, 0, 0, 1, 32'h200, 0, 0);
        tick(0, 0, 0, 0, 0, 0, 1, 32'h300);
        tick(0, 1, 1, 0, 0, 0, 0, 0);
        checks++;
        if ({PC, IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_Valid}
            !== {32'h300, 32'd0, 32'd0, 1'b0}) begin
            errors++;
            $display("FAIL pending_apply: pc=%h ins=%h pc4=%h v=%b, required pc=300 ins=0 pc4=0 v=0",
                     PC, IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_Valid);
        end
        run(1);
        checks++;
        if ({PC, IF_ID_Instruction, IF_ID_Valid} !== {32'h304, imem_word(32'h300), 1'b1}) begin
            errors++;
            $display("FAIL pending_cleared: pc=%h ins=%h v=%b, required pc=304 ins=%h v=1",
                     PC, IF_ID_Instruction, IF_ID_Valid, imem_word(32'h300));
        end
    endtask

    task automatic test_wrap_align;
        tick(0, 1, 1, 0, 0, 0, 1, 32'hFFFF_FFFC);
        run(1);
        checks++;
        if ({PC, IF_ID_PCPlus4} !== {32'h0, 32'h0}) begin
            errors++;
            $display("FAIL pc_wrap: pc=%h pc4=%h, required 0 0", PC, IF_ID_PCPlus4);
        end
        tick(0, 1, 1, 0, 1, 32'h43, 0, 0);
        checks++;
        if (PC !== 32'h40) begin
            errors++;
            $display("FAIL target_align: pc=%h, required 40", PC);
        end
    endtask

    task automatic test_reset_pending;
        tick(0, 0, 0, 0, 1, 32'h500, 0, 0);
        tick(1, 0, 0, 0, 0, 0, 0, 0);
        run(1);
        checks++;
        if ({PC, IF_ID_Valid, IF_ID_Instruction} !== {RST_PC + 32'd4, 1'b1, imem_word(RST_PC)}) begin
            errors++;
            $display("FAIL reset_discards_pending: pc=%h v=%b ins=%h, required pc=%h v=1 ins=%h",
                     PC, IF_ID_Valid, IF_ID_Instruction, RST_PC + 32'd4, imem_word(RST_PC));
        end
    endtask

    task automatic test_saturation;
        tick(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) tick(0, 0, 1, 1, 0, 0, 0, 0);
        checks++;
        if ({StallCount, FlushCount, PC} !== {CNT_MAX, CNT_MAX, RST_PC}) begin
            errors++;
            $display("FAIL counter_saturate: sc=%0d fc=%0d pc=%h, required sc=%0d fc=%0d pc=%h",
                     StallCount, FlushCount, PC, CNT_MAX, CNT_MAX, RST_PC);
        end
    endtask

    task automatic test_random;
        logic br, jp, pcw;
        for (int i = 0; i < 400; i++) begin
            br  = ($urandom_range(0, 5) == 0);
            jp  = ($urandom_range(0, 7) == 0);
            pcw = ($urandom_range(0, 3) != 0);
            tick(($urandom_range(0, 60) == 0), pcw, ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 6) == 0), br, $urandom, jp, $urandom);
            checks++;
            if ({PC, IMemAddr, IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_Valid, StallCount, FlushCount}
                !== {m_pc, m_pc, m_instr, m_pc4, m_valid, m_sc, m_fc}) begin
                errors++;
                $display("FAIL random[%0d]: pc=%h addr=%h ins=%h pc4=%h v=%b sc=%0d fc=%0d, required pc=%h ins=%h pc4=%h v=%b sc=%0d fc=%0d",
                         i, PC, IMemAddr, IF_ID_Instruction, IF_ID_PCPlus4, IF_ID_Valid, StallCount, FlushCount,
                         m_pc, m_instr, m_pc4, m_valid, m_sc, m_fc);
            end
        end
    endtask

    initial begin
        m_pc = 0; m_pt = 0; m_instr = 0; m_pc4 = 0; m_pv = 0; m_valid = 0; m_sc = 0; m_fc = 0;
        test_reset;
        test_free_run;
        test_stall;
        test_branch_flush;
        test_jump_priority;
        test_pending;
        test_wrap_align;
        test_reset_pending;
        test_saturation;
        tick(1, 0, 0, 0, 0, 0, 0, 0);
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC register, the next-PC select, and the IF/ID pipeline register.
- Consumes the hazard unit's stall and flush controls (PCWrite, IF_ID_Write, IF_ID_Flush) and the redirect requests from EX/MEM (branch, jump).
- Produces the instruction and PC+4 consumed by decode and by the hazard unit's register compare.
- Holds a redirect that arrives during a stall and applies it on the first unstalled cycle, so no redirect is lost.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of the saturating performance counters.

Ports:
- Clk  in  1  pipeline clock, rising edge.
- Rst  in  1  synchronous, active-high reset.
- PCWrite  in  1  hazard unit: 1 = PC may update.
- IF_ID_Write  in  1  hazard unit: 1 = IF/ID may load.
- IF_ID_Flush  in  1  hazard unit: 1 = load bubble into IF/ID.
- BranchTaken  in  1  taken-branch redirect request (PCAdd_Mux_AddOrBranch).
- BranchTarget  in  32  branch target address.
- JumpTaken  in  1  jump redirect request.
- JumpTarget  in  32  jump target address.
- IMemAddr  out  32  instruction memory address; combinational, equals PC.
- IMemData  in  32  instruction word; combinational read of IMemAddr.
- PC  out  32  current PC register.
- IF_ID_Instruction  out  32  registered instruction.
- IF_ID_PCPlus4  out  32  registered PC+4.
- IF_ID_Valid  out  1  1 = IF/ID holds a real instruction.
- StallCount  out  CNT_W  cycles with PCWrite=0, saturating.
- FlushCount  out  CNT_W  cycles with IF_ID_Flush=1, saturating.

Behaviour:
- Reset (Rst=1 at a clock edge) sets:
  - PC=RESET_PC.
  - IF_ID_Instruction=0, IF_ID_PCPlus4=0, IF_ID_Valid=0.
  - PendValid=0, PendTarget=0.
  - StallCount=0, FlushCount=0.
- Reset overrides every other input. Applying reset mid-stall or with a pending redirect discards that state.
- Redirect target: JumpTarget if JumpTaken, else BranchTarget. Jump has priority when both are asserted. Bits [1:0] of every target are forced to 0.
- PC+4 is computed modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
- When PCWrite=1, next PC is chosen in this priority order:
  - redirect target, if JumpTaken or BranchTaken;
  - PendTarget, if PendValid;
  - otherwise PC+4.
- PendValid is cleared on every PCWrite=1 cycle.
- When PCWrite=0:
  - PC holds.
  - If JumpTaken or BranchTaken, then PendValid<=1 and PendTarget<=redirect target. A later redirect during the same stall overwrites the earlier one.
  - Otherwise pending state holds.
- IF/ID priority: Flush, then Write, then hold.
  - IF_ID_Flush=1: Instruction<=0 (nop), PCPlus4<=0, Valid<=0. Flush wins over IF_ID_Write.
  - IF_ID_Write=1 and this cycle consumes PendValid (PCWrite=1, PendValid=1, no new redirect): load nop with Valid=0. The word at the current PC is wrong-path.
  - IF_ID_Write=1 otherwise: Instruction<=IMemData, PCPlus4<=PC+4, Valid<=1.
  - IF_ID_Write=0 and no flush: all IF/ID outputs hold.
- Fetch latency: an instruction at PC appears on IF_ID_Instruction one cycle after PC is presented.
- Counters increment by 1 per qualifying cycle and saturate at 2^CNT_W-1 with no wrap. They are cleared only by reset.
- PCWrite=1 with IF_ID_Write=0 is legal. The PC advances and the IF/ID register holds; the hazard unit is responsible for consistency.

Decomposition:
- Shared pipeline package holds:
  - NOP_INSTR = 32'h0000_0000;
  - opcode constants (J=6'b000010, JAL=6'b000011, SW=6'b101011, LW=6'b100011);
  - WORD_BYTES = 4.
- One natural sub-module: if_id_reg, the IF/ID register with write-enable, flush priority and valid bit.
- PC, next-PC logic, pending-redirect state and counters stay in fetch_stage.

Test Plan:
- Reset, then 4 free-running cycles (PCWrite=IF_ID_Write=1) -> PC=0,4,8,C,10; IF_ID_PCPlus4 follows one cycle later; Valid=1 from cycle 2.
- PCWrite=IF_ID_Write=0 for 3 cycles at PC=8 -> PC and IF/ID hold; StallCount=3; then release, PC=C.
- BranchTaken=1, BranchTarget=0x40, IF_ID_Flush=1 on the same cycle -> PC=0x40; IF/ID=nop with Valid=0; FlushCount=1.
- JumpTaken=1 (0x100) and BranchTaken=1 (0x80) on the same cycle -> PC=0x100.
- During a stall: BranchTaken to 0x200 on stall cycle 1, then JumpTaken to 0x300 on stall cycle 2; release with no redirect -> PC=0x300, IF/ID=nop with Valid=0, PendValid cleared.
- PC=32'hFFFF_FFFC with free run -> next PC=0; target 0x43 -> PC=0x40; Rst asserted while PendValid=1 -> PC=RESET_PC and PendValid=0.
